pipelined_param_adder: RTL and testbench
========================================

Name: pipelined_param_adder

Overview:
- Parametrised, pipelined successor to the fixed-width ripple full adders used in the oscillator datapath. It is used for phase accumulation and mixing.
- The carry chain is split into SEG-bit segments, with one register stage per segment, so wide adds close timing at audio-clock multiples.
- Accepts one operand pair per enabled cycle and returns the result a fixed number of cycles later, with a valid flag.
- Optional unsigned saturation mode for amplitude sums.

Parameters:
- WIDTH, 18, operand/sum width in bits (>=2).
- SEG, 6, bits per pipeline segment (1..WIDTH). NSEG = ceil(WIDTH/SEG); the last segment may be narrower.
- SATURATE, 0, 0 = wrap (modular) result; 1 = unsigned saturate to all-ones on carry out.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  pipeline advance enable. When 0, all pipeline registers hold.
- in_valid  in  1  a/b/c_in carry a valid operation this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- c_in  in  1  carry in.
- sum  out  WIDTH  result (wrapped or saturated per SATURATE).
- c_out  out  1  unsigned carry out of bit WIDTH-1, always the raw carry.
- ovf  out  1  two's-complement signed overflow: carry into MSB xor carry out of MSB.
- out_valid  out  1  sum/c_out/ovf belong to a valid operation.

Behaviour:
- Reset, sampled on clk rising edge with reset=1:
  - All pipeline registers cleared, including data, carries and valid bits.
  - sum=0, c_out=0, ovf=0, out_valid=0 from the next edge.
  - Reset overrides en. Operations in flight when reset is asserted are discarded and never emerge.
- Pipeline advance:
  - On an edge with en=1, every stage moves forward by one. Stage 0 captures a, b, c_in and in_valid.
  - On an edge with en=0, nothing changes; outputs hold their values, including out_valid.
- Latency: exactly NSEG enabled edges from capture to outputs. Example: WIDTH=18, SEG=6 gives a latency of 3. NSEG=1 gives a single registered adder.
- Segmentation and carry handling:
  - Stage k adds segment k (bits k*SEG up to min((k+1)*SEG, WIDTH)-1) of a and b, plus the carry registered by stage k-1. Stage 0 uses c_in.
  - Stage k registers its segment sum and carry out.
  - Higher operand segments are skewed through delay registers so each arrives at its stage in step with its carry.
  - Completed lower segments are delayed (deskewed) so all sum bits of one operation present in the same cycle.
  - No combinational path spans more than one segment.
- Throughput: one operation per enabled cycle. Back-to-back valid inputs produce back-to-back valid outputs.
- Bubbles: in_valid=0 entries propagate as bubbles. out_valid=0 for them; sum/c_out/ovf are don't-care then but must be deterministic, i.e. computed from the captured a/b.
- Saturation:
  - SATURATE=1 and final carry=1: sum = all ones.
  - c_out is the true carry; ovf is computed from the unsaturated add.
  - SATURATE=0: sum = (a+b+c_in) mod 2^WIDTH.
- Final output stage: c_out, ovf, saturation select and out_valid are all registered in the last stage. No extra latency beyond NSEG.
- Wrap-around: the full carry chain must propagate across every segment boundary (e.g. 0x3FFFF + 1).
- Simultaneous reset and in_valid: reset wins and the input is dropped.

Test Plan:
- WIDTH=18, SEG=6, SATURATE=0:
  - a=0x3FFFF, b=0x00000, c_in=1, in_valid=1 -> after 3 edges: sum=0x00000, c_out=1, ovf=0, out_valid=1 for exactly one cycle.
  - Full carry ripple across both segment boundaries; signed overflow: a=0x1FFFF, b=0x00001, c_in=0 -> sum=0x20000, c_out=0, ovf=1.
- Streaming: 8 consecutive valid pairs (a=i*0x1111, b=0x0F0F0, c_in=i[0]) -> 8 consecutive out_valid cycles starting at edge 3. Each sum matches the reference model, in order.
- Stall: issue 2 ops, hold en=0 for 4 cycles mid-flight, then en=1 -> outputs and out_valid frozen during the stall. Results emerge after exactly 3 enabled edges each, values unchanged.
- Reset mid-operation: 3 ops in flight, assert reset one cycle -> out_valid=0 and sum=0 on the next edge. None of the 3 results ever appear; a new op after reset returns in 3 edges.
- SATURATE=1: a=0x30000, b=0x20000, c_in=0 -> sum=0x3FFFF, c_out=1. Also a=0x10000, b=0x0FFFF -> sum=0x1FFFF, c_out=0 (no saturation).
- Parameter sweep (WIDTH=18/SEG=18, WIDTH=18/SEG=4, WIDTH=24/SEG=8) with 1000 random ops each -> latency equals NSEG; all results match a+b+c_in.

Source files
------------

// File: rtl/pipelined_param_adder.sv
// Segmented pipelined adder: one SEG-bit carry segment per register stage, with
// upper operand bits skewed in and finished sum bits deskewed so a result emerges whole.
module pipelined_param_adder #(
    parameter int WIDTH    = 18,
    parameter int SEG      = 6,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             out_valid
);
    localparam int NSEG = (WIDTH + SEG - 1) / SEG;

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        localparam int LO   = k * SEG;
        localparam int REM  = WIDTH - LO;
        localparam int W    = (REM < SEG) ? REM : SEG;
        localparam bit LAST = (k == NSEG - 1);

        // cur_a/cur_b hold operand bits LO and up; the low W bits are this stage's segment
        logic [REM-1:0]  cur_a;
        logic [REM-1:0]  cur_b;
        logic            cur_c;
        logic            cur_v;
        logic [W:0]      seg;
        logic [LO+W-1:0] s_lin;
        logic [LO+W-1:0] s_next;
        logic [LO+W-1:0] s_q;
        logic            c_q;
        logic            v_q;

        if (k == 0) begin : g_src
            assign cur_a = a;
            assign cur_b = b;
            assign cur_c = c_in;
            assign cur_v = in_valid;
            assign s_lin = seg[W-1:0];
        end else begin : g_src
            assign cur_a = g_stage[k-1].g_fwd.a_q;
            assign cur_b = g_stage[k-1].g_fwd.b_q;
            assign cur_c = g_stage[k-1].c_q;
            assign cur_v = g_stage[k-1].v_q;
            assign s_lin = {seg[W-1:0], g_stage[k-1].s_q};
        end

        assign seg    = (W+1)'(cur_a[W-1:0]) + (W+1)'(cur_b[W-1:0]) + (W+1)'(cur_c);
        assign s_next = (LAST && SATURATE != 0 && seg[W]) ? '1 : s_lin;

        always_ff @(posedge clk) begin
            if (reset) begin
                s_q <= '0;
                c_q <= 1'b0;
                v_q <= 1'b0;
            end else if (en) begin
                s_q <= s_next;
                c_q <= seg[W];
                v_q <= cur_v;
            end
        end

        if (!LAST) begin : g_fwd
            logic [REM-W-1:0] a_q;
            logic [REM-W-1:0] b_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (en) begin
                    a_q <= cur_a[REM-1:W];
                    b_q <= cur_b[REM-1:W];
                end
            end
        end else begin : g_out
            logic ovf_q;

            // carry into the MSB is recovered from the MSB sum bit and its operands
            always_ff @(posedge clk) begin
                if (reset) begin
                    ovf_q <= 1'b0;
                end else if (en) begin
                    ovf_q <= seg[W] ^ (seg[W-1] ^ cur_a[W-1] ^ cur_b[W-1]);
                end
            end

            assign sum       = s_q;
            assign c_out     = c_q;
            assign ovf       = ovf_q;
            assign out_valid = v_q;
        end
    end
endmodule

// File: tb/tb_pipelined_param_adder.sv
// Bench for pipelined_param_adder: five parameter sets share one stimulus stream and
// are each compared every cycle against an arithmetic delay-line reference.
module tb_pipelined_param_adder;
    localparam int NI = 5;

    function automatic int cfg_w(input int i);
        return (i == 4) ? 24 : 18;
    endfunction

    function automatic int cfg_s(input int i);
        case (i)
            2:       return 18;
            3:       return 4;
            4:       return 8;
            default: return 6;
        endcase
    endfunction

    function automatic int cfg_sat(input int i);
        return (i == 1) ? 1 : 0;
    endfunction

    typedef struct packed {
        logic        v;
        logic [23:0] a;
        logic [23:0] b;
        logic        c;
    } op_t;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic        en       = 1'b0;
    logic        in_valid = 1'b0;
    logic        c_in     = 1'b0;
    logic [23:0] a_in     = '0;
    logic [23:0] b_in     = '0;

    logic [NI-1:0][23:0] sum_w;
    logic [NI-1:0]       co_w;
    logic [NI-1:0]       ov_w;
    logic [NI-1:0]       vo_w;

    int checks = 0;
    int passed = 0;
    bit armed  = 1'b0;

    always #5 clk = ~clk;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    for (genvar i = 0; i < NI; i++) begin : g_dut
        localparam int W   = cfg_w(i);
        localparam int S   = cfg_s(i);
        localparam int SAT = cfg_sat(i);
        localparam int N   = (W + S - 1) / S;
        localparam longint unsigned MASK = (64'd1 << W) - 64'd1;

        logic [W-1:0] s;
        logic         co;
        logic         ov;
        logic         vo;
        op_t          pipe[$];
        op_t          head = '0;

        pipelined_param_adder #(.WIDTH(W), .SEG(S), .SATURATE(SAT)) dut (
            .clk      (clk),
            .reset    (reset),
            .en       (en),
            .in_valid (in_valid),
            .a        (a_in[W-1:0]),
            .b        (b_in[W-1:0]),
            .c_in     (c_in),
            .sum      (s),
            .c_out    (co),
            .ovf      (ov),
            .out_valid(vo)
        );

        assign sum_w[i] = 24'(s);
        assign co_w[i]  = co;
        assign ov_w[i]  = ov;
        assign vo_w[i]  = vo;

        // head is the operation whose result must be on the outputs after this edge
        always @(posedge clk) begin
            if (reset) begin
                pipe.delete();
                for (int k = 0; k < N - 1; k++) pipe.push_back('0);
                head = '0;
            end else if (en) begin
                pipe.push_back(op_t'{v: in_valid, a: a_in & 24'(MASK), b: b_in & 24'(MASK), c: c_in});
                head = pipe.pop_front();
            end
        end

        always @(negedge clk) begin
            longint unsigned full;
            longint unsigned raw;
            longint unsigned exp_sum;
            logic            exp_co;
            logic            exp_ov;
            if (armed) begin
                full    = 64'(head.a) + 64'(head.b) + 64'(head.c);
                exp_co  = full[W];
                raw     = full & MASK;
                exp_sum = (SAT != 0 && exp_co) ? MASK : raw;
                exp_ov  = (head.a[W-1] == head.b[W-1]) && (raw[W-1] != head.a[W-1]);
                check($sformatf("inst%0d out_valid", i), 64'(vo), 64'(head.v));
                check($sformatf("inst%0d sum", i), 64'(s), exp_sum);
                check($sformatf("inst%0d c_out", i), 64'(co), 64'(exp_co));
                check($sformatf("inst%0d ovf", i), 64'(ov), 64'(exp_ov));
            end
        end
    end

    function automatic logic [23:0] rnd24();
        case ($urandom_range(0, 7))
            0:       return 24'hFFFFFF;
            1:       return 24'h000000;
            2:       return 24'h03FFFF;
            default: return 24'($urandom);
        endcase
    endfunction

    // One op on the 18/6 wrap instance (0) and its saturating twin (1), 3 edges later.
    task automatic op_lit(input string name, input logic [23:0] av, input logic [23:0] bv,
                          input logic cv, input logic [23:0] exp_sum, input logic exp_co,
                          input logic exp_ov, input logic [23:0] exp_sat);
        @(negedge clk);
        a_in = av; b_in = bv; c_in = cv; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check({name, " valid"}, 64'(vo_w[0]), 64'd1);
        check({name, " sum"}, 64'(sum_w[0]), 64'(exp_sum));
        check({name, " c_out"}, 64'(co_w[0]), 64'(exp_co));
        check({name, " ovf"}, 64'(ov_w[0]), 64'(exp_ov));
        check({name, " sat sum"}, 64'(sum_w[1]), 64'(exp_sat));
        @(negedge clk);
        check({name, " single cycle"}, 64'(vo_w[0]), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [14:0] vmask;
        logic [23:0] s3;
        logic [23:0] s4;
        logic        ghost;
        int          ops;

        repeat (2) @(negedge clk);
        reset = 1'b0;
        en    = 1'b1;
        armed = 1'b1;
        check("reset out_valid", 64'(vo_w[0]), 64'd0);
        check("reset sum", 64'(sum_w[0]), 64'd0);
        check("reset c_out", 64'(co_w[0]), 64'd0);
        check("reset ovf", 64'(ov_w[0]), 64'd0);

        op_lit("carry ripple", 24'h3FFFF, 24'h00000, 1'b1, 24'h00000, 1'b1, 1'b0, 24'h3FFFF);
        op_lit("signed ovf", 24'h1FFFF, 24'h00001, 1'b0, 24'h20000, 1'b0, 1'b1, 24'h20000);
        op_lit("sat carry", 24'h30000, 24'h20000, 1'b0, 24'h10000, 1'b1, 1'b1, 24'h3FFFF);
        op_lit("sat none", 24'h10000, 24'h0FFFF, 1'b0, 24'h1FFFF, 1'b0, 1'b0, 24'h1FFFF);

        // streaming: ops driven at negedges 0..7 must be valid at negedges 3..10
        vmask = '0;
        s3 = '0;
        s4 = '0;
        for (int t = 0; t < 15; t++) begin
            @(negedge clk);
            vmask[t] = vo_w[0];
            if (t == 3) s3 = sum_w[0];
            if (t == 4) s4 = sum_w[0];
            if (t < 8) begin
                a_in = 24'(t * 32'h1111); b_in = 24'h0F0F0; c_in = t[0]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
        end
        check("stream valid window", 64'(vmask), 64'h07F8);
        check("stream op0 sum", 64'(s3), 64'h0F0F0);
        check("stream op1 sum", 64'(s4), 64'h10202);

        // stall with the first result on the outputs and the second still inside
        @(negedge clk);
        a_in = 24'h12345; b_in = 24'h0ABCD; c_in = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        a_in = 24'h3FFFF; b_in = 24'h3FFFF; c_in = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("stall op0 valid", 64'(vo_w[0]), 64'd1);
        check("stall op0 sum", 64'(sum_w[0]), 64'h1CF13);
        en = 1'b0;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            check("stall frozen valid", 64'(vo_w[0]), 64'd1);
            check("stall frozen sum", 64'(sum_w[0]), 64'h1CF13);
        end
        en = 1'b1;
        @(negedge clk);
        check("stall op1 valid", 64'(vo_w[0]), 64'd1);
        check("stall op1 sum", 64'(sum_w[0]), 64'h3FFFF);
        check("stall op1 c_out", 64'(co_w[0]), 64'd1);
        @(negedge clk);
        check("stall after valid", 64'(vo_w[0]), 64'd0);
        repeat (4) @(negedge clk);

        // reset while ops are in flight; the op presented with reset is dropped
        @(negedge clk);
        a_in = 24'h00ABC; b_in = 24'h00DEF; c_in = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        a_in = 24'h11111; b_in = 24'h02222; c_in = 1'b1;
        @(negedge clk);
        a_in = 24'h3FFFF; b_in = 24'h00001; c_in = 1'b0; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; in_valid = 1'b0;
        check("reset flush valid", 64'(vo_w[0]), 64'd0);
        check("reset flush sum", 64'(sum_w[0]), 64'd0);
        check("reset flush c_out", 64'(co_w[0]), 64'd0);
        ghost = 1'b0;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            ghost = ghost | vo_w[0];
        end
        check("no ghost after reset", 64'(ghost), 64'd0);
        op_lit("after reset", 24'h2AAAA, 24'h15556, 1'b0, 24'h00000, 1'b1, 1'b0, 24'h3FFFF);

        // random traffic with random stalls and rare resets
        ops = 0;
        for (int cyc = 0; cyc < 8000 && ops < 1000; cyc++) begin
            @(negedge clk);
            en       = ($urandom_range(0, 9) != 0);
            reset    = ($urandom_range(0, 249) == 0);
            in_valid = ($urandom_range(0, 3) != 0);
            a_in     = rnd24();
            b_in     = rnd24();
            c_in     = 1'($urandom_range(0, 1));
            if (en && in_valid && !reset) ops++;
        end
        @(negedge clk);
        reset = 1'b0; en = 1'b1; in_valid = 1'b0;
        repeat (8) @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
